// File: rtl/fir_dout_sink.sv
// fir_dout_sink: receive-side endpoint for the FIR output stream.
//   Captures VIN/DIN samples into a frame of FRAME_LEN accepted samples.
//   The samples are buffered in a first-word-fall-through FIFO, and the FIFO
//   is drained through a RD_VALID/RD_READY port.
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   START              one-cycle pulse, arms a capture (honoured in IDLE only)
//   VIN, DIN           input sample valid / signed sample
//   RD_READY           consumer accepts head this cycle
//   RD_VALID/DATA/LAST FIFO head (DATA/LAST forced to 0 when empty)
//   BUSY, FULL, EMPTY, COUNT  status
//   OVERFLOW           sticky: sample dropped in CAPTURE because the FIFO was full
//   FRAME_DONE         one-cycle pulse after the final read of a frame
//   CHECKSUM           (only with FIR_SINK_CHECKSUM_EN) 24-bit running sum of
//                      accepted samples
// Optional feature macro: FIR_SINK_CHECKSUM_EN
module fir_dout_sink #(
  parameter int DATA_WIDTH = 13,
  parameter int DEPTH      = 16,
  parameter int FRAME_LEN  = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic                    VIN,
  input  logic [DATA_WIDTH-1:0]   DIN,
  input  logic                    RD_READY,
  output logic                    RD_VALID,
  output logic [DATA_WIDTH-1:0]   RD_DATA,
  output logic                    RD_LAST,
  output logic                    BUSY,
  output logic                    FULL,
  output logic                    EMPTY,
  output logic [$clog2(DEPTH):0]  COUNT,
  output logic                    OVERFLOW,
`ifdef FIR_SINK_CHECKSUM_EN
  output logic [23:0]             CHECKSUM,
`endif
  output logic                    FRAME_DONE
);
  localparam int AW  = $clog2(DEPTH);
  localparam int FCW = $clog2(FRAME_LEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       cnt_q;
  logic [FCW-1:0]    fcnt_q;
  logic              ovf_q, done_q, done_d;
  logic [DATA_WIDTH:0] mem_q [DEPTH];   // {last, sample}

  logic rd_fire, wr_en, ovf_set, last_w, arm;
  logic [DATA_WIDTH:0] head;

  assign FULL     = (cnt_q == (AW+1)'(DEPTH));
  assign EMPTY    = (cnt_q == '0);
  assign COUNT    = cnt_q;
  assign RD_VALID = !EMPTY;
  assign BUSY     = (state_q != S_IDLE);
  assign OVERFLOW = ovf_q;
  assign FRAME_DONE = done_q;

  assign head    = mem_q[rptr_q];
  assign RD_DATA = EMPTY ? '0 : head[DATA_WIDTH-1:0];
  assign RD_LAST = EMPTY ? 1'b0 : head[DATA_WIDTH];

  assign rd_fire = RD_VALID && RD_READY;
  assign arm     = (state_q == S_IDLE) && START;
  assign last_w  = (fcnt_q == FCW'(FRAME_LEN - 1));
  // A full FIFO still takes a sample when a read frees a slot on the same edge.
  assign wr_en   = (state_q == S_CAPTURE) && VIN && (!FULL || rd_fire);
  assign ovf_set = (state_q == S_CAPTURE) && VIN && FULL && !rd_fire;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE:    if (START) state_d = S_CAPTURE;
      S_CAPTURE: if (wr_en && last_w) state_d = S_DRAIN;
      S_DRAIN: begin
        // The last accept left at least one entry, so this read empties the FIFO.
        if (rd_fire && cnt_q == (AW+1)'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (wr_en)   wptr_q <= wptr_q + AW'(1);
      if (rd_fire) rptr_q <= rptr_q + AW'(1);
      case ({wr_en, rd_fire})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (arm)        fcnt_q <= '0;
      else if (wr_en) fcnt_q <= fcnt_q + FCW'(1);
      if (arm)          ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
    end
  end

  // Storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wptr_q] <= {last_w, DIN};
  end

`ifdef FIR_SINK_CHECKSUM_EN
  logic [23:0] chk_q;
  assign CHECKSUM = chk_q;
  always_ff @(posedge CLK) begin
    if (RST || arm) chk_q <= '0;
    else if (wr_en) chk_q <= chk_q + 24'($signed(DIN));
  end
`endif

endmodule

// File: tb/tb_fir_dout_sink.sv
// Bench for fir_dout_sink: two instances (FRAME_LEN=4 and FRAME_LEN=64),
// selected by 'sel'. Expected {last,data} pushed on drive, popped on read.
module tb_fir_dout_sink;
  localparam int DW = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, vin, rdy, sel;
  logic [DW-1:0] din;

  logic a_start, a_vin, b_start, b_vin;
  assign a_start = !sel && start;
  assign a_vin   = !sel && vin;
  assign b_start = sel && start;
  assign b_vin   = sel && vin;

  logic a_valid, a_last, a_busy, a_full, a_empty, a_ovf, a_done;
  logic b_valid, b_last, b_busy, b_full, b_empty, b_ovf, b_done;
  logic [DW-1:0] a_data, b_data;
  logic [4:0] a_count, b_count;
`ifdef FIR_SINK_CHECKSUM_EN
  logic [23:0] a_chk, b_chk;
`endif

  fir_dout_sink #(.DATA_WIDTH(DW), .DEPTH(16), .FRAME_LEN(4)) u_a (
    .CLK(clk), .RST(rst), .START(a_start), .VIN(a_vin), .DIN(din), .RD_READY(rdy),
    .RD_VALID(a_valid), .RD_DATA(a_data), .RD_LAST(a_last), .BUSY(a_busy),
    .FULL(a_full), .EMPTY(a_empty), .COUNT(a_count), .OVERFLOW(a_ovf),
`ifdef FIR_SINK_CHECKSUM_EN
    .CHECKSUM(a_chk),
`endif
    .FRAME_DONE(a_done));

  fir_dout_sink #(.DATA_WIDTH(DW), .DEPTH(16), .FRAME_LEN(64)) u_b (
    .CLK(clk), .RST(rst), .START(b_start), .VIN(b_vin), .DIN(din), .RD_READY(rdy),
    .RD_VALID(b_valid), .RD_DATA(b_data), .RD_LAST(b_last), .BUSY(b_busy),
    .FULL(b_full), .EMPTY(b_empty), .COUNT(b_count), .OVERFLOW(b_ovf),
`ifdef FIR_SINK_CHECKSUM_EN
    .CHECKSUM(b_chk),
`endif
    .FRAME_DONE(b_done));

  // Selected-instance view
  logic o_valid, o_last, o_busy, o_full, o_empty, o_ovf, o_done;
  logic [DW-1:0] o_data;
  logic [4:0] o_count;
  assign o_valid = sel ? b_valid : a_valid;
  assign o_last  = sel ? b_last  : a_last;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_full  = sel ? b_full  : a_full;
  assign o_empty = sel ? b_empty : a_empty;
  assign o_ovf   = sel ? b_ovf   : a_ovf;
  assign o_done  = sel ? b_done  : a_done;
  assign o_data  = sel ? b_data  : a_data;
  assign o_count = sel ? b_count : a_count;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [DW:0] sbq[$];

  // Check the current read (if any) against the scoreboard, then advance one cycle.
  task automatic step();
    logic [DW:0] e;
    if (o_done) done_cnt++;
    if (o_valid && rdy) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got data %0d last %0b, scoreboard empty", $signed(o_data), o_last);
      end else begin
        e = sbq.pop_front();
        if ({o_last, o_data} !== e) begin
          errors++;
          $display("FAIL rd_data: got last %0b data %0d, want last %0b data %0d",
                   o_last, $signed(o_data), e[DW], $signed(e[DW-1:0]));
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic do_reset();
    start = 0; vin = 0; rdy = 0; din = '0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    sbq.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1; step(); start = 0;
  endtask

  // Drain the scoreboard with RD_READY=1, then idle a few cycles to catch FRAME_DONE.
  task automatic drain();
    int budget = 300;
    vin = 0; rdy = 1;
    while (sbq.size() != 0 && budget > 0) begin step(); budget--; end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries left, want 0", sbq.size());
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    sel = 1;
    do_reset();
    chk("rst_empty", o_empty, 1); chk("rst_count", o_count, 0);
    chk("rst_data", o_data, 0);   chk("rst_last", o_last, 0);
    chk("rst_ovf", o_ovf, 0);     chk("rst_done", o_done, 0);
    vin = 1; din = 13'd5;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_valid", o_valid, 0);
    end
    vin = 0;
    chk("idle_empty", o_empty, 1); chk("idle_count", o_count, 0); chk("idle_busy", o_busy, 0);
  endtask

  task automatic test_basic();
    logic [DW-1:0] v [4];
    v[0] = 13'sd1; v[1] = -13'sd2; v[2] = 13'sd3; v[3] = -13'sd4;
    sel = 0;
    do_reset();
    rdy = 1;
    pulse_start();
    chk("basic_busy", o_busy, 1);
    for (int i = 0; i < 4; i++) begin
      vin = 1; din = v[i];
      sbq.push_back({(i == 3), v[i]});
      step();
    end
    drain();
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_busy_after", o_busy, 0);
    chk("basic_empty_after", o_empty, 1);
  endtask

  task automatic test_overflow();
    sel = 1;
    do_reset();
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      vin = 1; din = DW'(100 + i);
      if (i < 16) sbq.push_back({1'b0, DW'(100 + i)});
      step();
    end
    vin = 0;
    chk("ovf_count", o_count, 16); chk("ovf_full", o_full, 1);
    chk("ovf_flag", o_ovf, 1);     chk("ovf_busy", o_busy, 1);
    drain();
    chk("ovf_empty_after", o_empty, 1);
    chk("ovf_sticky", o_ovf, 1);
  endtask

  task automatic test_full_rw();
    sel = 1;
    do_reset();
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      vin = 1; din = DW'(200 + i);
      sbq.push_back({1'b0, DW'(200 + i)});
      step();
    end
    vin = 0;
    chk("frw_full", o_full, 1);
    chk("frw_ovf0", o_ovf, 0);
    vin = 1; rdy = 1; din = -13'sd777;
    sbq.push_back({1'b0, -13'sd777});
    step();
    vin = 0; rdy = 0;
    chk("frw_count", o_count, 16);
    chk("frw_ovf", o_ovf, 0);
    drain();
    chk("frw_empty_after", o_empty, 1);
  endtask

  task automatic test_reset_mid();
    sel = 1;
    do_reset();
    pulse_start();
    for (int i = 0; i < 10; i++) begin vin = 1; din = DW'(i); step(); end
    vin = 0;
    chk("mid_count_pre", o_count, 10);
    do_reset();
    chk("mid_empty", o_empty, 1); chk("mid_busy", o_busy, 0);
    repeat (4) step();
    chk("mid_no_done", done_cnt, 0);
    rdy = 1;
    pulse_start();
    for (int i = 0; i < 64; i++) begin
      vin = 1; din = DW'(i - 32);
      sbq.push_back({(i == 63), DW'(i - 32)});
      step();
    end
    drain();
    chk("mid_done_cnt", done_cnt, 1);
    chk("mid_busy_after", o_busy, 0);
  endtask

`ifdef FIR_SINK_CHECKSUM_EN
  task automatic test_checksum();
    logic [DW-1:0] v [4];
    logic [23:0] sum;
    v[0] = 13'sd4095; v[1] = -13'sd4096; v[2] = 13'sd100; v[3] = -13'sd1;
    sum = '0;
    sel = 0;
    do_reset();
    rdy = 1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      vin = 1; din = v[i];
      sum = sum + {{(24-DW){v[i][DW-1]}}, v[i]};
      sbq.push_back({(i == 3), v[i]});
      step();
    end
    drain();
    chk("checksum", a_chk, sum);
  endtask
`endif

  initial begin
    rst = 0; start = 0; vin = 0; rdy = 0; din = '0; sel = 0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_overflow();
    test_full_rw();
    test_reset_mid();
`ifdef FIR_SINK_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
